// File: rtl/stream_hub_pkg.sv
// Shared types and address/width helpers for the stream hub.
package stream_hub_pkg;

  // Status slot: IDLE accepts a status request, PEND waits for the upstream grant.
  typedef enum logic {
    STAT_IDLE = 1'b0,
    STAT_PEND = 1'b1
  } stat_state_e;

  function automatic int unsigned msg_width(input int unsigned addr_bits,
                                            input int unsigned bit_width);
    return addr_bits + bit_width;
  endfunction

  function automatic int unsigned cfg_addr(input int unsigned addr_bits);
    return (32'd1 << addr_bits) - 32'd1;
  endfunction

  function automatic int unsigned stat_addr(input int unsigned addr_bits);
    return (32'd1 << addr_bits) - 32'd2;
  endfunction

endpackage

// File: rtl/stream_hub_fifo.sv
// Per-port downstream FIFO; head word is presented directly from storage.
module stream_hub_fifo #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [BIT_WIDTH-1:0] push_data_i,
  output logic                 push_rdy_c_o,
  output logic                 pop_val_o,
  output logic [BIT_WIDTH-1:0] pop_data_o,
  input  logic                 pop_rdy_i
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 push, pop;

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  assign pop_val_o    = (count_q != '0);
  assign pop          = pop_val_o & pop_rdy_i;
  assign push_rdy_c_o = (count_q != CW'(FIFO_DEPTH)) | pop;
  assign push         = push_i & push_rdy_c_o;
  assign pop_data_o   = mem_q[rd_ptr_q];

  // Storage array, written only on push; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/stream_hub.sv
// Host/peripheral message hub: address-decoded downstream FIFOs, config and
// status slots, and a round-robin upstream arbiter into one output register.
module stream_hub
  import stream_hub_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned MW = msg_width(ADDR_BITS, BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MW-1:0]        recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [MW-1:0]        send_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] port_send_msg [N_PORTS],
  output logic                 port_send_val [N_PORTS],
  input  logic                 port_send_rdy [N_PORTS],
  input  logic [BIT_WIDTH-1:0] port_recv_msg [N_PORTS],
  input  logic                 port_recv_val [N_PORTS],
  output logic                 port_recv_rdy [N_PORTS]
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [ADDR_BITS-1:0] CFG_A  = ADDR_BITS'(cfg_addr(ADDR_BITS));
  localparam logic [ADDR_BITS-1:0] STAT_A = ADDR_BITS'(stat_addr(ADDR_BITS));
  localparam logic [ADDR_BITS-1:0] NP_A   = ADDR_BITS'(N_PORTS);

  logic [ADDR_BITS-1:0] in_addr;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 is_data, is_cfg, is_stat, port_en, port_rdy;
  logic                 accept, drop, stat_cap, can_load;
  logic [N_PORTS-1:0]   fifo_rdy, fifo_push;

  logic [N_PORTS-1:0]   en_q, en_d;
  logic [BIT_WIDTH-1:0] drop_q, drop_d;
  logic [BIT_WIDTH-1:0] stat_data_q, stat_data_d;
  stat_state_e          state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 out_val_q, out_val_d;
  logic [MW-1:0]        out_msg_q, out_msg_d;

  logic                 rr_hit, grant_port;
  logic [PW-1:0]        rr_sel;
  logic [BIT_WIDTH-1:0] rr_data;
  int unsigned          rr_dist, rr_best;

  assign in_addr  = recv_msg[MW-1 -: ADDR_BITS];
  assign in_data  = recv_msg[BIT_WIDTH-1:0];
  assign is_data  = (in_addr < NP_A);
  assign is_cfg   = (in_addr == CFG_A);
  assign is_stat  = (in_addr == STAT_A);
  assign send_val = out_val_q;
  assign send_msg = out_msg_q;
  assign can_load = ~out_val_q | send_rdy;

  // Look up enable and FIFO space for the addressed data port.
  always_comb begin
    port_en  = 1'b0;
    port_rdy = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (in_addr == ADDR_BITS'(p)) begin
        port_en  = en_q[p];
        port_rdy = fifo_rdy[p];
      end
    end
  end

  // Host-side ready: only enabled data ports and the busy status slot can stall.
  always_comb begin
    recv_rdy = 1'b1;
    if (is_data && port_en) recv_rdy = port_rdy;
    else if (is_stat)       recv_rdy = (state_q == STAT_IDLE);
  end

  assign accept   = recv_val & recv_rdy;
  assign drop     = accept & ((is_data & ~port_en) | ~(is_data | is_cfg | is_stat));
  assign stat_cap = accept & is_stat;

  // Round-robin pick: the valid port closest at or after the pointer wins.
  always_comb begin
    rr_hit  = 1'b0;
    rr_sel  = '0;
    rr_data = '0;
    rr_best = N_PORTS;
    rr_dist = 0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      rr_dist = (j >= 32'(ptr_q)) ? j - 32'(ptr_q) : j + N_PORTS - 32'(ptr_q);
      if (port_recv_val[j] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_hit  = 1'b1;
        rr_sel  = PW'(j);
        rr_data = port_recv_msg[j];
      end
    end
  end

  // Next state: config, drop counter, status FSM, arbiter and output register.
  always_comb begin
    en_d        = en_q;
    drop_d      = drop_q;
    stat_data_d = stat_data_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_val_d   = out_val_q;
    out_msg_d   = out_msg_q;
    grant_port  = 1'b0;

    if (accept && is_cfg) en_d = in_data[N_PORTS-1:0];

    if (stat_cap) begin
      stat_data_d = drop_q;
      drop_d      = drop ? BIT_WIDTH'(1) : '0;
    end else if (drop && drop_q != '1) begin
      drop_d = drop_q + BIT_WIDTH'(1);
    end

    case (state_q)
      STAT_IDLE: if (stat_cap) state_d = STAT_PEND;
      STAT_PEND: if (can_load) state_d = STAT_IDLE;
      default:   state_d = STAT_IDLE;
    endcase

    if (can_load) begin
      out_val_d = 1'b0;
      if (state_q == STAT_PEND) begin
        out_val_d = 1'b1;
        out_msg_d = {STAT_A, stat_data_q};
      end else if (rr_hit) begin
        grant_port = 1'b1;
        out_val_d  = 1'b1;
        out_msg_d  = {ADDR_BITS'(rr_sel), rr_data};
        ptr_d      = (rr_sel == PW'(N_PORTS - 1)) ? '0 : rr_sel + PW'(1);
      end
    end
  end

  // Peripheral ready is the grant itself.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      port_recv_rdy[p] = grant_port && (rr_sel == PW'(p));
    end
  end

  // Hub control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q        <= '1;
      drop_q      <= '0;
      stat_data_q <= '0;
      state_q     <= STAT_IDLE;
      ptr_q       <= '0;
      out_val_q   <= 1'b0;
      out_msg_q   <= '0;
    end else begin
      en_q        <= en_d;
      drop_q      <= drop_d;
      stat_data_q <= stat_data_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_val_q   <= out_val_d;
      out_msg_q   <= out_msg_d;
    end
  end

  // One downstream FIFO per peripheral port.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign fifo_push[p] = accept & is_data & port_en & (in_addr == ADDR_BITS'(p));

    stream_hub_fifo #(
      .BIT_WIDTH (BIT_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (fifo_push[p]),
      .push_data_i (in_data),
      .push_rdy_c_o(fifo_rdy[p]),
      .pop_val_o   (port_send_val[p]),
      .pop_data_o  (port_send_msg[p]),
      .pop_rdy_i   (port_send_rdy[p])
    );
  end

endmodule

// File: tb/tb_stream_hub.sv
// Scoreboard bench for stream_hub at default parameters (MW=19, CFG=7, STAT=6).
module tb_stream_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] recv_msg, send_msg;
  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [15:0] port_send_msg [4];
  logic        port_send_val [4];
  logic        port_send_rdy [4];
  logic [15:0] port_recv_msg [4];
  logic        port_recv_val [4];
  logic        port_recv_rdy [4];

  logic [18:0] exp_send [$];
  logic [15:0] exp_port [4][$];
  int          pass_cnt  = 0;
  int          check_cnt = 0;

  stream_hub dut (
    .clk          (clk),
    .reset        (reset),
    .recv_msg     (recv_msg),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .send_msg     (send_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .port_send_msg(port_send_msg),
    .port_send_val(port_send_val),
    .port_send_rdy(port_send_rdy),
    .port_recv_msg(port_recv_msg),
    .port_recv_val(port_recv_val),
    .port_recv_rdy(port_recv_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host message; called and returns just after a rising edge.
  task automatic host_send(input logic [2:0] a, input logic [15:0] d);
    int n = 0;
    recv_msg = {a, d};
    recv_val = 1'b1;
    @(negedge clk);
    while (!recv_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_cnt++;
    if (recv_rdy) pass_cnt++;
    else $display("FAIL host_timeout: addr %0d data %h never accepted", a, d);
    @(posedge clk);
    #1;
    recv_val = 1'b0;
  endtask

  // Peripheral p offers two words 0xA000 + p*0x100 + w.
  task automatic drive_port(input int p);
    for (int w = 0; w < 2; w++) begin
      int n = 0;
      port_recv_msg[p] = 16'hA000 + 16'(p * 256) + 16'(w);
      port_recv_val[p] = 1'b1;
      @(negedge clk);
      while (!port_recv_rdy[p] && n < 100) begin
        n++;
        @(negedge clk);
      end
      check_cnt++;
      if (port_recv_rdy[p]) pass_cnt++;
      else $display("FAIL port_grant_timeout: port %0d word %0d", p, w);
      @(posedge clk);
      #1;
    end
    port_recv_val[p] = 1'b0;
  endtask

  // Monitor: every completed output transfer is checked against the queues.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (send_val && send_rdy) begin
          if (exp_send.size() == 0) begin
            check_cnt++;
            $display("FAIL send_unexpected: got %h required no word", send_msg);
          end else begin
            check("send_word", 32'(send_msg), 32'(exp_send.pop_front()));
          end
        end
        for (int p = 0; p < 4; p++) begin
          if (port_send_val[p] && port_send_rdy[p]) begin
            if (exp_port[p].size() == 0) begin
              check_cnt++;
              $display("FAIL port_unexpected: port %0d got %h required no word", p, port_send_msg[p]);
            end else begin
              check($sformatf("port%0d_word", p), 32'(port_send_msg[p]), 32'(exp_port[p].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset    = 1'b1;
    recv_msg = '0;
    recv_val = 1'b0;
    send_rdy = 1'b1;
    for (int p = 0; p < 4; p++) begin
      port_send_rdy[p] = 1'b1;
      port_recv_msg[p] = '0;
      port_recv_val[p] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_send_val", 32'(send_val), 0);
    check("rst_send_msg", 32'(send_msg), 0);
    for (int p = 0; p < 4; p++) check($sformatf("rst_port%0d_val", p), 32'(port_send_val[p]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(1);

    // Single word to port 2: valid exactly one cycle, one cycle after acceptance.
    exp_port[2].push_back(16'h1234);
    host_send(3'd2, 16'h1234);
    @(negedge clk);
    check("p2_val_next_cycle", 32'(port_send_val[2]), 1);
    check("p2_msg", 32'(port_send_msg[2]), 32'h1234);
    @(negedge clk);
    check("p2_val_one_cycle", 32'(port_send_val[2]), 0);
    @(posedge clk);
    #1;

    // FIFO full back-pressure on port 1, then push-while-pop on release.
    port_send_rdy[1] = 1'b0;
    for (int i = 0; i < 5; i++) exp_port[1].push_back(16'h1100 + 16'(i));
    for (int i = 0; i < 4; i++) host_send(3'd1, 16'h1100 + 16'(i));
    recv_msg = {3'd1, 16'h1104};
    recv_val = 1'b1;
    @(negedge clk);
    check("full_stall_a", 32'(recv_rdy), 0);
    @(negedge clk);
    check("full_stall_b", 32'(recv_rdy), 0);
    @(posedge clk);
    #1;
    port_send_rdy[1] = 1'b1;
    @(negedge clk);
    check("full_push_pop", 32'(recv_rdy), 1);
    @(posedge clk);
    #1;
    recv_val = 1'b0;
    cycles(8);

    // Disable port 2, two drops, then status reports 2 and clears the counter.
    host_send(3'd7, 16'h000B);
    host_send(3'd2, 16'hAAAA);
    host_send(3'd5, 16'h0001);
    exp_send.push_back({3'd6, 16'h0002});
    host_send(3'd6, 16'h0000);
    cycles(4);
    exp_send.push_back({3'd6, 16'h0000});
    host_send(3'd6, 16'h0000);
    cycles(4);
    host_send(3'd7, 16'h000F);

    // Round robin over ports 0,1,3 with a status jumping in under back-pressure.
    send_rdy = 1'b0;
    exp_send.push_back({3'd0, 16'hA000});
    exp_send.push_back({3'd6, 16'h0000});
    exp_send.push_back({3'd1, 16'hA100});
    exp_send.push_back({3'd3, 16'hA300});
    exp_send.push_back({3'd0, 16'hA001});
    exp_send.push_back({3'd1, 16'hA101});
    exp_send.push_back({3'd3, 16'hA301});
    fork
      drive_port(0);
      drive_port(1);
      drive_port(3);
      host_send(3'd6, 16'h0000);
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("stall_send_val", 32'(send_val), 1);
          check("stall_send_msg", 32'(send_msg), 32'({3'd0, 16'hA000}));
        end
        @(posedge clk);
        #1;
        send_rdy = 1'b1;
      end
    join
    cycles(6);

    // Mid-operation reset with buffered words, a held output, pending status and config.
    send_rdy = 1'b0;
    port_send_rdy[0] = 1'b0;
    host_send(3'd0, 16'hB000);
    host_send(3'd0, 16'hB001);
    host_send(3'd0, 16'hB002);
    port_recv_msg[2] = 16'hC000;
    port_recv_val[2] = 1'b1;
    @(posedge clk);
    #1;
    port_recv_val[2] = 1'b0;
    host_send(3'd6, 16'h0000);
    host_send(3'd7, 16'h0001);
    host_send(3'd5, 16'h0000);
    @(negedge clk);
    check("pre_rst_out_held", 32'(send_msg), 32'({3'd2, 16'hC000}));
    check("pre_rst_p0_val", 32'(port_send_val[0]), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_send_val", 32'(send_val), 0);
    check("mid_rst_send_msg", 32'(send_msg), 0);
    check("mid_rst_p0_val", 32'(port_send_val[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_p0_val", 32'(port_send_val[0]), 0);
    check("post_rst_send_val", 32'(send_val), 0);
    @(posedge clk);
    #1;
    port_send_rdy[0] = 1'b1;
    send_rdy = 1'b1;
    cycles(4);
    exp_port[2].push_back(16'hD000);
    host_send(3'd2, 16'hD000);
    exp_port[3].push_back(16'hD003);
    host_send(3'd3, 16'hD003);
    exp_send.push_back({3'd6, 16'h0000});
    host_send(3'd6, 16'h0000);
    cycles(5);

    check("send_queue_drained", 32'(exp_send.size()), 0);
    for (int p = 0; p < 4; p++) check($sformatf("port%0d_queue_drained", p), 32'(exp_port[p].size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
